// File: rtl/imem_fetch_if.sv
// Purpose: bundles the imem read port, the redirect request and the fetch-to-decode
// valid/ready handshake of the instruction fetch stage.
//   imem_addr      fetch -> imem    word address
//   imem_q         imem  -> fetch   combinational read data
//   redirect_valid/redirect_pc      pc reload request (branch/trap/mret)
//   if_valid/if_ready               item handshake to decode
//   if_instr/if_pc/if_fault         fetched item payload
// master = the fetch stage, slave = its environment (imem, redirect source, decode).
interface imem_fetch_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] imem_addr;
    logic [N-1:0]      imem_q;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [N-1:0]      if_instr;
    logic [31:0]       if_pc;
    logic              if_fault;

    modport master (
        output imem_addr, if_valid, if_instr, if_pc, if_fault,
        input  imem_q, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_addr, if_valid, if_instr, if_pc, if_fault,
        output imem_q, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/imem_fetch.sv
// Purpose: instruction fetch stage. Owns the PC, addresses the combinational imem,
// registers the returned word into a one-entry output buffer and hands it to decode
// over valid/ready. Redirects reload the PC; a misaligned target produces a single
// fault item (nop payload) and fetching stops until the next redirect.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   bus          imem_fetch_if master (imem port, redirect, decode handshake)
//   fetch_count  number of non-fault, non-squashed transfers (wraps)
module imem_fetch #(
    parameter int          N        = 32,
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    imem_fetch_if.master        bus,
    output logic [31:0]         fetch_count
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [N-1:0] NOP_INSTR = N'(32'h0000_0013);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [N-1:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic load_s;
    logic transfer_s;

    assign load_s     = ~valid_q | bus.if_ready;
    assign transfer_s = valid_q & bus.if_ready;

    // Next-state and output-register values; a redirect overrides load and stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        fault_d = fault_q;
        count_d = count_q;
        if (bus.redirect_valid) begin
            // Any transfer in this cycle is squashed, so the count is left alone.
            pc_d = bus.redirect_pc;
            if (bus.redirect_pc[1:0] == 2'b00) begin
                state_d = RUN;
                valid_d = 1'b0;
                fault_d = 1'b0;
            end else begin
                state_d = FAULT;
                valid_d = 1'b1;
                fault_d = 1'b1;
                ifpc_d  = bus.redirect_pc;
                instr_d = NOP_INSTR;
            end
        end else begin
            if (transfer_s && !fault_q) begin
                count_d = count_q + 32'd1;
            end else begin
                count_d = count_q;
            end
            case (state_q)
                BOOT: begin
                    // One idle cycle; imem_addr already shows RESET_PC for the first capture.
                    state_d = RUN;
                end
                RUN: begin
                    if (load_s) begin
                        instr_d = bus.imem_q;
                        ifpc_d  = pc_q;
                        fault_d = 1'b0;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end else begin
                        pc_d    = pc_q;
                        valid_d = valid_q;
                    end
                end
                FAULT: begin
                    // No fetching here: the fault item drains and pc waits for a redirect.
                    if (transfer_s) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d = valid_q;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= 32'd0;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    // Word address truncates, so fetches past the last word alias back to word 0.
    assign bus.imem_addr = pc_q[ADDR_W+1:2];
    assign bus.if_valid  = valid_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = ifpc_q;
    assign bus.if_fault  = fault_q;
    assign fetch_count   = count_q;
endmodule
